// File: rtl/reg_file_ctx.sv
// Parametrised register file with two combinational read ports, an accumulator tap (R0)
// and a context engine that spills/fills every register over valid/ready handshakes.
//
// state | meaning
// IDLE  | normal register-file operation, writes accepted
// SPILL | streaming core[index] out on sp_*, index advances on sp_valid && sp_ready
// FILL  | requesting core[index] on fl_*, index advances on fl_valid
module reg_file_ctx #(
    parameter int W      = 8,
    parameter int PW     = 4,
    parameter bit BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  dat_in,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_addr,
    input  logic [PW-1:0] rd_addrA,
    input  logic [PW-1:0] rd_addrB,
    output logic [W-1:0]  datA_out,
    output logic [W-1:0]  datB_out,
    output logic [W-1:0]  acc_out,
    input  logic          spill_start,
    input  logic          fill_start,
    output logic          sp_valid,
    input  logic          sp_ready,
    output logic [PW-1:0] sp_addr,
    output logic [W-1:0]  sp_data,
    output logic          fl_req,
    output logic [PW-1:0] fl_addr,
    input  logic          fl_valid,
    input  logic [W-1:0]  fl_data,
    output logic          busy,
    output logic          done
);
    localparam int D = 1 << PW;
    localparam logic [PW:0] LAST = (PW+1)'(D - 1);
    localparam logic [PW:0] ONE  = (PW+1)'(1);

    typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

    state_t        state;
    logic [PW:0]   idx;
    logic [W-1:0]  core [D];
    logic [PW-1:0] idx_lo;
    logic          wr_eff;
    logic          idx_last;

    assign idx_lo   = idx[PW-1:0];
    assign wr_eff   = wr_en && (state == IDLE);
    assign idx_last = (idx == LAST);

    // Bypass only covers host writes; fill writes become visible the following cycle.
    assign datA_out = (rd_addrA == '0) ? '0 :
                      (BYPASS && wr_eff && (wr_addr == rd_addrA)) ? dat_in : core[rd_addrA];
    assign datB_out = (rd_addrB == '0) ? '0 :
                      (BYPASS && wr_eff && (wr_addr == rd_addrB)) ? dat_in : core[rd_addrB];
    assign acc_out  = core[0];

    assign sp_addr = idx_lo;
    assign sp_data = core[idx_lo];
    assign fl_addr = idx_lo;
    assign busy    = sp_valid | fl_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) core[i] <= '0;
            state    <= IDLE;
            idx      <= '0;
            sp_valid <= 1'b0;
            fl_req   <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_en) core[wr_addr] <= dat_in;
                    if (spill_start) begin
                        state    <= SPILL;
                        idx      <= '0;
                        sp_valid <= 1'b1;
                    end else if (fill_start) begin
                        state  <= FILL;
                        idx    <= '0;
                        fl_req <= 1'b1;
                    end
                end
                SPILL: begin
                    if (sp_ready) begin
                        if (idx_last) begin
                            state    <= IDLE;
                            idx      <= '0;
                            sp_valid <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            idx <= idx + ONE;
                        end
                    end
                end
                FILL: begin
                    if (fl_valid) begin
                        core[idx_lo] <= fl_data;
                        if (idx_last) begin
                            state  <= IDLE;
                            idx    <= '0;
                            fl_req <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            idx <= idx + ONE;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    idx      <= '0;
                    sp_valid <= 1'b0;
                    fl_req   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_file_ctx.sv
// Bench for reg_file_ctx: a BYPASS=1 and a BYPASS=0 instance share stimulus and are
// checked against an array model of the register contents.
module tb_reg_file_ctx;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] dat_in;
    logic       wr_en;
    logic [3:0] wr_addr, rd_addrA, rd_addrB;
    logic       spill_start, fill_start, sp_ready, fl_valid;
    logic [7:0] fl_data;

    logic [7:0] datA, datB, acc, sp_data;
    logic [3:0] sp_addr, fl_addr;
    logic       sp_valid, fl_req, busy, done;

    logic [7:0] datA0, datB0, acc0, sp_data0;
    logic [3:0] sp_addr0, fl_addr0;
    logic       sp_valid0, fl_req0, busy0, done0;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mdl [16];

    always #5 clk = ~clk;

    reg_file_ctx #(.W(8), .PW(4), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .dat_in(dat_in), .wr_en(wr_en), .wr_addr(wr_addr),
        .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .datA_out(datA), .datB_out(datB),
        .acc_out(acc), .spill_start(spill_start), .fill_start(fill_start),
        .sp_valid(sp_valid), .sp_ready(sp_ready), .sp_addr(sp_addr), .sp_data(sp_data),
        .fl_req(fl_req), .fl_addr(fl_addr), .fl_valid(fl_valid), .fl_data(fl_data),
        .busy(busy), .done(done)
    );

    reg_file_ctx #(.W(8), .PW(4), .BYPASS(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .dat_in(dat_in), .wr_en(wr_en), .wr_addr(wr_addr),
        .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .datA_out(datA0), .datB_out(datB0),
        .acc_out(acc0), .spill_start(spill_start), .fill_start(fill_start),
        .sp_valid(sp_valid0), .sp_ready(sp_ready), .sp_addr(sp_addr0), .sp_data(sp_data0),
        .fl_req(fl_req0), .fl_addr(fl_addr0), .fl_valid(fl_valid), .fl_data(fl_data),
        .busy(busy0), .done(done0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    // Expected read value while the engine is idle.
    function automatic logic [7:0] exp_rd(input logic [3:0] a, input bit byp);
        if (a == 4'd0) return 8'h00;
        if (byp && wr_en && (wr_addr == a)) return dat_in;
        return mdl[a];
    endfunction

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; dat_in = d;
        step();
        wr_en = 1'b0;
        mdl[a] = d;
    endtask

    task automatic check_all_regs(input string tag);
        wr_en = 1'b0;
        for (int i = 1; i < 16; i++) begin
            rd_addrA = 4'(i);
            rd_addrB = 4'(i);
            #1;
            chk({tag, "_A"}, 32'(datA), 32'(mdl[i]));
            chk({tag, "_B0"}, 32'(datB0), 32'(mdl[i]));
        end
        chk({tag, "_acc"}, 32'(acc), 32'(mdl[0]));
    endtask

    // mode 0: sp_ready high; mode 1: sp_ready every other cycle, fill_start collides
    // with spill_start, a second spill_start and wr_en pulses arrive mid-spill.
    task automatic run_spill(input int mode);
        int         ntx, ndone;
        logic       pv, pr;
        logic [3:0] pa;
        logic [7:0] pd;
        spill_start = 1'b1;
        fill_start  = (mode == 1);
        step();
        spill_start = 1'b0;
        fill_start  = 1'b0;
        ntx = 0; ndone = 0; pv = 1'b0; pr = 1'b1; pa = '0; pd = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            sp_ready    = (mode == 1) ? (cyc % 2 == 1) : 1'b1;
            spill_start = (mode == 1) && (cyc == 5);
            wr_en       = (mode == 1) && (cyc % 3 == 0);
            wr_addr     = 4'($urandom);
            dat_in      = 8'($urandom);
            settle();
            if (done) begin
                ndone++;
                break;
            end
            if (cyc == 0) begin
                chk("spill_entry_valid", 32'(sp_valid), 32'd1);
                chk("spill_entry_no_fill", 32'(fl_req), 32'd0);
                chk("spill_entry_busy", 32'(busy), 32'd1);
            end
            if (pv && !pr) begin
                chk("stall_hold_addr", 32'(sp_addr), 32'(pa));
                chk("stall_hold_data", 32'(sp_data), 32'(pd));
            end
            if (sp_valid && sp_ready) begin
                chk("spill_addr", 32'(sp_addr), 32'(ntx % 16));
                chk("spill_data", 32'(sp_data), 32'(mdl[ntx % 16]));
                ntx++;
            end
            pv = sp_valid; pr = sp_ready; pa = sp_addr; pd = sp_data;
            step();
        end
        chk("spill_transfers", 32'(ntx), 32'd16);
        chk("spill_done_seen", 32'(ndone), 32'd1);
        chk("spill_done_busy", 32'(busy), 32'd0);
        chk("spill_done_valid", 32'(sp_valid), 32'd0);
        wr_en = 1'b0; spill_start = 1'b0; sp_ready = 1'b0;
        step();
        settle();
        chk("spill_done_pulse", 32'(done), 32'd0);
        chk("spill_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; dat_in = '0; wr_en = 1'b0; wr_addr = '0; rd_addrA = '0; rd_addrB = '0;
        spill_start = 1'b0; fill_start = 1'b0; sp_ready = 1'b0; fl_valid = 1'b0; fl_data = '0;
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sp_valid", 32'(sp_valid), 32'd0);
        chk("rst_fl_req", 32'(fl_req), 32'd0);
        chk("rst_sp_addr", 32'(sp_addr), 32'd0);
        chk("rst_fl_addr", 32'(fl_addr), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        wr(4'd3, 8'hA5);
        wr(4'd0, 8'h11);
        rd_addrA = 4'd3; rd_addrB = 4'd0;
        settle();
        chk("rd_A3", 32'(datA), 32'hA5);
        chk("rd_B0_zero", 32'(datB), 32'h00);
        chk("acc_r0", 32'(acc), 32'h11);

        // Same-cycle write/read of R5 on both bypass variants.
        rd_addrA = 4'd5; wr_en = 1'b1; wr_addr = 4'd5; dat_in = 8'h3C;
        settle();
        chk("bypass1_same", 32'(datA), 32'h3C);
        chk("bypass0_same", 32'(datA0), 32'h00);
        step();
        wr_en = 1'b0; mdl[5] = 8'h3C;
        settle();
        chk("bypass1_next", 32'(datA), 32'h3C);
        chk("bypass0_next", 32'(datA0), 32'h3C);
        step();
        rd_addrA = 4'd0; wr_en = 1'b1; wr_addr = 4'd0; dat_in = 8'h11;
        settle();
        chk("bypass_r0_never", 32'(datA), 32'h00);
        step();
        wr_en = 1'b0;

        for (int k = 0; k < 24; k++) begin
            rd_addrA = 4'($urandom);
            rd_addrB = 4'($urandom);
            wr_en    = 1'($urandom);
            wr_addr  = (k % 3 == 0) ? rd_addrA : 4'($urandom);
            dat_in   = 8'($urandom);
            settle();
            chk("rand_A_byp1", 32'(datA), 32'(exp_rd(rd_addrA, 1'b1)));
            chk("rand_B_byp1", 32'(datB), 32'(exp_rd(rd_addrB, 1'b1)));
            chk("rand_A_byp0", 32'(datA0), 32'(exp_rd(rd_addrA, 1'b0)));
            if (wr_en) mdl[wr_addr] = dat_in;
            step();
        end
        wr_en = 1'b0;

        for (int i = 0; i < 16; i++) wr(4'(i), 8'(i + 1));
        run_spill(0);
        run_spill(1);
        check_all_regs("after_spill");

        // fl_valid while idle must not touch the registers.
        fl_valid = 1'b1; fl_data = 8'h55;
        step();
        fl_valid = 1'b0;
        check_all_regs("idle_flvalid");

        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            fl_valid = (cyc % 3 == 2);
            fl_data  = 8'hF0 | 8'(n);
            wr_en    = (cyc % 4 == 1);
            wr_addr  = 4'($urandom);
            dat_in   = 8'($urandom);
            rd_addrA = 4'($urandom);
            settle();
            if (done) break;
            chk("fill_req", 32'(fl_req), 32'd1);
            chk("fill_addr", 32'(fl_addr), 32'(n % 16));
            chk("fill_read_stored", 32'(datA), 32'((rd_addrA == 4'd0) ? 8'h00 : mdl[rd_addrA]));
            if (fl_valid && fl_req) begin
                mdl[n % 16] = 8'hF0 | 8'(n);
                n++;
            end
            step();
        end
        chk("fill_words", 32'(n), 32'd16);
        chk("fill_done_busy", 32'(busy), 32'd0);
        chk("fill_done_req", 32'(fl_req), 32'd0);
        fl_valid = 1'b0; wr_en = 1'b0;
        step();
        settle();
        chk("fill_done_pulse", 32'(done), 32'd0);
        check_all_regs("after_fill");

        // Reset in the middle of a spill.
        spill_start = 1'b1;
        step();
        spill_start = 1'b0; sp_ready = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            settle();
            if (sp_addr == 4'd7) break;
            step();
        end
        chk("abort_reached_7", 32'(sp_addr), 32'd7);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        chk("abort_sp_valid", 32'(sp_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sp_addr", 32'(sp_addr), 32'd0);
        chk("abort_sp_data", 32'(sp_data), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_acc", 32'(acc), 32'd0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            settle();
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_idle", 32'(busy), 32'd0);
        end
        sp_ready = 1'b0;
        check_all_regs("abort_regs");
        run_spill(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_file_ctx.md
Name: reg_file_ctx

Overview:
- Parametrised successor to the 8-bit, 16-entry accumulator register file.
- Generalises data width and depth and adds a second read port with optional write-to-read bypass.
- Adds a context engine that spills every register to memory, or fills every register from memory, over valid/ready handshakes.
- Sits between decode/ALU and data memory. Used for call/interrupt context save and restore.

Parameters:
- W, 8, data width in bits.
- PW, 4, address pointer width; depth D = 2**PW.
- BYPASS, 1, 1 = a read of the register being written this cycle returns dat_in; 0 = the read returns the stored value.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dat_in  in  W  write data.
- wr_en  in  1  write enable.
- wr_addr  in  PW  write address.
- rd_addrA  in  PW  read address, port A.
- rd_addrB  in  PW  read address, port B.
- datA_out  out  W  read data, port A (combinational).
- datB_out  out  W  read data, port B (combinational).
- acc_out  out  W  always core[0] (accumulator, R0).
- spill_start  in  1  one-cycle pulse: begin spill.
- fill_start  in  1  one-cycle pulse: begin fill.
- sp_valid  out  1  spill word valid.
- sp_ready  in  1  memory accepts spill word.
- sp_addr  out  PW  index of the spill word.
- sp_data  out  W  spill word.
- fl_req  out  1  fill request for fl_addr.
- fl_addr  out  PW  index requested.
- fl_valid  in  1  fill data valid.
- fl_data  in  W  fill data.
- busy  out  1  engine in SPILL or FILL.
- done  out  1  one-cycle pulse when a spill or fill completes.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all D registers = 0, state = IDLE, index = 0.
  - sp_valid = 0, fl_req = 0, busy = 0, done = 0, sp_addr = fl_addr = 0.
- Reset asserted mid-spill or mid-fill aborts the operation immediately; no done pulse.
- Reads are combinational:
  - datA_out = 0 when rd_addrA == 0, else core[rd_addrA].
  - datB_out follows the same rule on rd_addrB.
  - acc_out = core[0] unconditionally.
- Bypass: with BYPASS=1, an effective write (wr_en, state IDLE) whose wr_addr equals a nonzero read address drives dat_in onto that read port in the same cycle. With BYPASS=0 the old value is read. Reads of address 0 are never bypassed.
- Writes are sequential: core[wr_addr] <= dat_in at posedge when wr_en is high and state is IDLE. wr_en is ignored in SPILL and FILL.
- State machine:
  - IDLE -> SPILL on spill_start. IDLE -> FILL on fill_start.
  - Both starts in the same cycle -> SPILL; fill_start is dropped.
  - Starts while busy are ignored.
  - Index resets to 0 on entry. busy = 1 in SPILL and FILL.
- SPILL:
  - sp_valid = 1, sp_addr = index, sp_data = core[index], R0 included.
  - The word transfers on a cycle with sp_valid && sp_ready; then index increments.
  - While sp_ready is low, sp_addr and sp_data are held stable.
  - After transferring index D-1: -> IDLE, done = 1 for one cycle, sp_valid = 0.
  - Minimum spill time is D cycles.
- FILL:
  - fl_req = 1, fl_addr = index.
  - On fl_valid: core[index] <= fl_data, index increments.
  - fl_valid while fl_req is low is ignored.
  - After writing index D-1: -> IDLE, done = 1, fl_req = 0.
  - During FILL, reads return the stored contents; a register's new value is visible from the cycle after its fill write. No bypass applies to fill writes.
- Index counter is PW+1 bits wide; completion is detected at index D-1 on transfer, with no wrap into a second pass.
- done is registered and never asserted in the same cycle as busy rising.

Test Plan:
- Reset, W=8, PW=4: write R3=0xA5, R0=0x11. Then: datA_out(3)=0xA5, datB_out(0)=0x00, acc_out=0x11.
- BYPASS=1: wr_en, wr_addr=5, dat_in=0x3C with rd_addrA=5 in the same cycle -> datA_out=0x3C that cycle. BYPASS=0 -> datA_out=0x00 that cycle, 0x3C the next.
- Spill with R_i = i+1 and sp_ready tied high -> 16 transfers (sp_addr 0..15, sp_data 1..16), done pulses once, busy low after. Same run with sp_ready low every other cycle -> identical sequence, sp_addr/sp_data held during stalls.
- Fill with fl_valid asserted every third cycle, fl_data = 0xF0|addr -> all registers = 0xF0..0xFF. wr_en pulses during the fill change nothing.
- spill_start and fill_start in the same cycle -> spill runs. A second spill_start mid-spill is ignored, exactly 16 transfers occur.
- rst_n dropped at spill index 7 -> all outputs 0 at once, registers 0, no done. A fresh spill then starts at index 0.
